// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: two-port arbiter onto a single-port memory with address-window decode and a starvation guard for port 1
module ext_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE = 32'h0000_1000,
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE = 32'h0002_0000,
  parameter int MAX_WAIT = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic p0_req_i,
  input  logic p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic p0_gnt_o,
  output logic p0_rvalid_o,
  output logic p0_err_o,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,
  input  logic p1_req_i,
  input  logic p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic p1_gnt_o,
  output logic p1_rvalid_o,
  output logic p1_err_o,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,
  output logic mem_en_o,
  output logic mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  localparam int MW = $clog2(MEM_SIZE);
  localparam int XW = ADDR_WIDTH + 1;
  // Window bounds carry an extra bit so the top of the address space cannot wrap into range.
  localparam logic [XW-1:0] LO = {1'b0, MEM_BASE};
  localparam logic [XW-1:0] HI = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE} - XW'(1);
  typedef enum logic {IDLE, FORCE1} state_t;
  state_t state;
  logic [7:0] wait_cnt, wait_nxt;
  logic resp_vld, resp_sel, resp_err, resp_we;
  logic sel, gnt, we, in_rng;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] rdata;
  assign p1_gnt_o = p1_req_i & (state == FORCE1 | ~p0_req_i);
  assign p0_gnt_o = p0_req_i & ~p1_gnt_o;
  assign sel = p1_gnt_o;
  assign gnt = p0_gnt_o | p1_gnt_o;
  assign addr = sel ? p1_addr_i : p0_addr_i;
  assign we = sel ? p1_we_i : p0_we_i;
  assign in_rng = ({1'b0, addr} >= LO) && ({1'b0, addr} <= HI);
  assign mem_en_o = gnt & in_rng;
  assign mem_we_o = mem_en_o & we;
  assign mem_be_o = sel ? p1_be_i : p0_be_i;
  assign mem_wdata_o = sel ? p1_wdata_i : p0_wdata_i;
  assign mem_addr_o = MW'(addr - MEM_BASE);
  assign wait_nxt = (~p1_req_i | p1_gnt_o) ? 8'd0 :
                    (wait_cnt < 8'(MAX_WAIT)) ? wait_cnt + 8'd1 : wait_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      wait_cnt <= 8'd0;
      resp_vld <= 1'b0;
      resp_sel <= 1'b0;
      resp_err <= 1'b0;
      resp_we <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      state <= (state == IDLE) ? ((p1_req_i && wait_nxt == 8'(MAX_WAIT)) ? FORCE1 : IDLE)
                               : ((p1_gnt_o || !p1_req_i) ? IDLE : FORCE1);
      resp_vld <= gnt;
      if (gnt) begin
        resp_sel <= sel;
        resp_err <= ~in_rng;
        resp_we <= we;
      end
    end
  end
  assign rdata = (resp_we | resp_err) ? '0 : mem_rdata_i;
  assign p0_rvalid_o = resp_vld & ~resp_sel;
  assign p1_rvalid_o = resp_vld & resp_sel;
  assign p0_err_o = p0_rvalid_o & resp_err;
  assign p1_err_o = p1_rvalid_o & resp_err;
  assign p0_rdata_o = p0_rvalid_o ? rdata : '0;
  assign p1_rdata_o = p1_rvalid_o ? rdata : '0;
endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb_ext_mem_arbiter: directed checks of arbitration, window decode, responses and reset
module tb_ext_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic p0_req, p0_we, p1_req, p1_we;
  logic [3:0] p0_be, p1_be, mem_be;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [31:0] mem [0:32767];
  int checks = 0, errors = 0;
  ext_mem_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_be_i(p0_be), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_err_o(p0_err), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_be_i(p1_be), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_err_o(p1_err), .p1_rdata_o(p1_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[16:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else mem_rdata <= mem[mem_addr[16:2]];
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic drv0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    p0_req = req; p0_we = we; p0_be = 4'hF; p0_addr = addr; p0_wdata = wdata;
  endtask
  task automatic drv1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    p1_req = req; p1_we = we; p1_be = 4'hF; p1_addr = addr; p1_wdata = wdata;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    mem[32767] = 32'hCAFE_F00D;
    mem_rdata = '0;
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    cyc(); cyc();
    check("rst_p0_rvalid", p0_rvalid, 0);
    check("rst_p1_rvalid", p1_rvalid, 0);
    check("rst_p0_err", p0_err, 0);
    check("rst_p1_err", p1_err, 0);
    check("rst_mem_en", mem_en, 0);
    rst_n = 1'b1;
    cyc();
    // port 0 write then read of 0x1004
    drv0(1, 1, 32'h1004, 32'hDEAD_BEEF);
    #2;
    check("wr_gnt0", p0_gnt, 1);
    check("wr_gnt1", p1_gnt, 0);
    check("wr_mem_en", mem_en, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", 32'(mem_addr), 32'h4);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    check("wr_rvalid", p0_rvalid, 1);
    check("wr_rdata", p0_rdata, 0);
    drv0(1, 0, 32'h1004, 0);
    #2;
    check("rd_gnt0", p0_gnt, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_addr", 32'(mem_addr), 32'h4);
    cyc();
    check("rd_rvalid", p0_rvalid, 1);
    check("rd_rdata", p0_rdata, 32'hDEAD_BEEF);
    check("rd_err", p0_err, 0);
    check("rd_p1_rvalid", p1_rvalid, 0);
    drv0(0, 0, 0, 0);
    cyc();
    check("idle_rvalid", p0_rvalid, 0);
    // contention: port 1 forced every 9th cycle
    drv0(1, 0, 32'h1000, 0);
    drv1(1, 0, 32'h1008, 0);
    for (int c = 1; c <= 18; c++) begin
      #2;
      check($sformatf("starve_gnt1_c%0d", c), p1_gnt, (c % 9 == 0));
      check($sformatf("starve_gnt0_c%0d", c), p0_gnt, (c % 9 != 0));
      cyc();
      if (c == 9) check("starve_rvalid1", p1_rvalid, 1);
      if (c == 10) check("starve_rvalid0", p0_rvalid, 1);
    end
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    cyc();
    // port 1 at the top of the window and just above it
    drv1(1, 0, 32'h0002_0FFC, 0);
    #2;
    check("top_gnt1", p1_gnt, 1);
    check("top_mem_en", mem_en, 1);
    check("top_mem_addr", 32'(mem_addr), 32'h1FFFC);
    cyc();
    check("top_rvalid", p1_rvalid, 1);
    check("top_err", p1_err, 0);
    check("top_rdata", p1_rdata, 32'hCAFE_F00D);
    drv1(1, 0, 32'h0002_1000, 0);
    #2;
    check("over_gnt1", p1_gnt, 1);
    check("over_mem_en", mem_en, 0);
    cyc();
    check("over_rvalid", p1_rvalid, 1);
    check("over_err", p1_err, 1);
    check("over_rdata", p1_rdata, 0);
    drv1(0, 0, 0, 0);
    // port 0 below base and at the top of the address space
    drv0(1, 0, 32'h0000_0FFC, 0);
    #2;
    check("below_gnt0", p0_gnt, 1);
    check("below_mem_en", mem_en, 0);
    cyc();
    check("below_err", p0_err, 1);
    check("below_rdata", p0_rdata, 0);
    drv0(1, 0, 32'hFFFF_FFFC, 0);
    #2;
    check("wrap_mem_en", mem_en, 0);
    cyc();
    check("wrap_rvalid", p0_rvalid, 1);
    check("wrap_err", p0_err, 1);
    check("wrap_rdata", p0_rdata, 0);
    // alternating single-cycle requests
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        drv0(1, 0, 32'h1004, 0);
        drv1(0, 0, 0, 0);
      end else begin
        drv0(0, 0, 0, 0);
        drv1(1, 0, 32'h0002_0FFC, 0);
      end
      #2;
      check($sformatf("alt_gnt_%0d", i), (i % 2 == 0) ? p0_gnt : p1_gnt, 1);
      cyc();
      check($sformatf("alt_rv0_%0d", i), p0_rvalid, (i % 2 == 0));
      check($sformatf("alt_rv1_%0d", i), p1_rvalid, (i % 2 == 1));
      check($sformatf("alt_rd_%0d", i), (i % 2 == 0) ? p0_rdata : p1_rdata,
            (i % 2 == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
      check($sformatf("alt_xrd_%0d", i), (i % 2 == 0) ? p1_rdata : p0_rdata, 0);
    end
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    cyc();
    // build up port 1 wait count, then reset with a grant pending
    drv0(1, 0, 32'h1004, 0);
    drv1(1, 0, 32'h1008, 0);
    for (int c = 0; c < 5; c++) cyc();
    #2;
    check("prerst_gnt0", p0_gnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("inrst_rvalid0", p0_rvalid, 0);
    check("inrst_rvalid1", p1_rvalid, 0);
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("postrst_rvalid0", p0_rvalid, 0);
    check("postrst_rvalid1", p1_rvalid, 0);
    drv0(1, 0, 32'h1004, 0);
    drv1(1, 0, 32'h1008, 0);
    for (int c = 1; c <= 9; c++) begin
      #2;
      check($sformatf("postrst_gnt1_c%0d", c), p1_gnt, (c == 9));
      cyc();
    end
    drv1(0, 0, 0, 0);
    #2;
    check("postrst_gnt0", p0_gnt, 1);
    cyc();
    check("postrst_rd_rvalid", p0_rvalid, 1);
    check("postrst_rd_rdata", p0_rdata, 32'hDEAD_BEEF);
    drv0(0, 0, 0, 0);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ext_mem_arbiter.md
Name: ext_mem_arbiter

Overview:
- Shares the single-port external instruction/data memory between two requesters.
- Port 0 is the AXI-side request/response path, which has high priority.
- Port 1 is a secondary requester, such as a debug loader or DMA.
- Adds address-window decode and an error response for out-of-range accesses.
- Adds a starvation guard so port 1 is never locked out.
- Sits between the request/response-to-memory adapters and the memory wrapper, replacing the permanently-granted memory port.

Parameters:
- DATA_WIDTH, 32, data width of both ports and the memory.
- ADDR_WIDTH, 32, byte-address width of the requester ports.
- MEM_BASE, 32'h0000_1000, byte base address of the memory window.
- MEM_SIZE, 32'h0002_0000, window size in bytes; power of two.
- MAX_WAIT, 8, consecutive denied cycles on port 1 before its grant is forced; range 1..255.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- p0_req_i  in  1  port 0 request.
- p0_we_i  in  1  port 0 write enable.
- p0_be_i  in  DATA_WIDTH/8  port 0 byte enables.
- p0_addr_i  in  ADDR_WIDTH  port 0 byte address.
- p0_wdata_i  in  DATA_WIDTH  port 0 write data.
- p0_gnt_o  out  1  port 0 grant, combinational.
- p0_rvalid_o  out  1  port 0 response valid.
- p0_err_o  out  1  port 0 response error.
- p0_rdata_o  out  DATA_WIDTH  port 0 read data.
- p1_*  same set as port 0, for port 1.
- mem_en_o  out  1  memory enable.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  DATA_WIDTH/8  memory byte enables.
- mem_addr_o  out  $clog2(MEM_SIZE)  byte offset into memory.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid one cycle after mem_en_o.

Behaviour:
- Interface decisions: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: all registered state is zero. rvalid_o and err_o are 0 on both ports. State is IDLE and wait_cnt is 0.
- No combinational output depends on registered state other than via the arbitration select.

Arbitration (combinational, same cycle):
- At most one grant per cycle.
- In IDLE: port 0 wins whenever p0_req_i=1; port 1 is granted only when p0_req_i=0.
- In FORCE1: port 1 wins if p1_req_i=1, even when p0_req_i=1.
- gnt is asserted only on a requesting port.

Memory drive:
- On a grant with an in-range address, mem_en_o=1.
- The winner's we, be and wdata pass straight to memory.
- mem_addr_o = (addr - MEM_BASE) truncated to $clog2(MEM_SIZE) bits.
- Otherwise mem_en_o=0 and mem_we_o=0.

Range check:
- An address is in range when MEM_BASE <= addr <= MEM_BASE+MEM_SIZE-1. Compute with ADDR_WIDTH+1 bits so there is no wrap at the top of the address space.
- An out-of-range request is still granted, but does not touch memory.

Response:
- Latency is exactly 1 cycle after the grant, for both reads and writes.
- Registers resp_sel and resp_err are set on each grant.
- The next cycle: rvalid_o=1 on the selected port only, for one cycle.
- rdata_o = mem_rdata_i on a read, 0 on a write or on an error.
- err_o = resp_err.
- Back-to-back grants give back-to-back responses. There is no backpressure; requesters must accept responses.

Starvation guard:
- wait_cnt (8-bit) increments each cycle p1_req_i=1 and p1_gnt_o=0, saturating at MAX_WAIT.
- wait_cnt clears when p1_gnt_o=1 or p1_req_i=0.
- IDLE -> FORCE1 when wait_cnt reaches MAX_WAIT while p1_req_i=1.
- FORCE1 -> IDLE on the cycle port 1 is granted, or when p1_req_i drops.
- In that transition cycle port 0 may win again if it is requesting.

Other boundary rules:
- A simultaneous reset mid-transaction drops the pending response: no rvalid after reset release.
- A misaligned address is passed through unmodified; the memory handles byte enables.

Test Plan:
- Single port 0 write 0xDEADBEEF to 0x1004, be=4'hF, then a read of 0x1004 -> gnt same cycle; mem_addr_o=0x4; read rvalid+1 cycle, rdata=0xDEADBEEF, err=0.
- Both ports request continuously, MAX_WAIT=8 -> port 0 is granted for 8 cycles; port 1 is granted on cycle 9; port 0 resumes on cycle 10; pattern repeats; wait_cnt ≤ 8.
- Port 1 alone reads 0x20FFC (last word) -> mem_addr_o=0x1FFFC, no error. Port 1 reads 0x21000 -> mem_en_o=0, response err=1, rdata=0.
- Port 0 reads 0x0FFC, below base, and 0xFFFF_FFFC -> err=1 with no memory access; no false in-range hit from wraparound.
- Alternating single-cycle requests on ports 0 and 1 with no overlap -> each granted immediately; rvalid is returned on the correct port every cycle with no cross-routing of rdata.
- Assert rst_ni low the cycle after a grant -> no rvalid after release; state=IDLE and wait_cnt=0 immediately (asynchronous); the next request is granted normally.
